// File: rtl/rsa_pkg.sv
// Shared definitions for the RSA modular-exponentiation controller:
// FSM state encoding, default operand widths and the smallest legal modulus.
package rsa_pkg;

  localparam int RSA_WIDTH      = 32;
  localparam int RSA_EXP_W      = 32;
  localparam int MODEXP_MIN_MOD = 2;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_CHECK     = 3'd1,
    ST_SQR_ISSUE = 3'd2,
    ST_SQR_WAIT  = 3'd3,
    ST_MUL_ISSUE = 3'd4,
    ST_MUL_WAIT  = 3'd5,
    ST_DONE      = 3'd6
  } modexp_state_e;

endpackage

// File: rtl/rsa_modexp_ctrl.sv
// rsa_modexp_ctrl: left-to-right square-and-multiply sequencer.
// Computes output_e = data_rx^exp_e mod mod_n by issuing every modular
// product to an external shared multiplier (start/done handshake).
//
// Optional build macro RSA_EXP_SKIP_EN: start the scan at the most
// significant set exponent bit with acc=base instead of scanning all
// EXP_W bits from acc=1. Results are identical; only the product count
// and cycle count shrink.
//
// Handshakes: a transfer happens on a rising clk edge where valid and
// ready are both high (in_valid/in_ready, out_valid/out_ready); the
// producer holds its data stable while valid is high and ready is low.
// mm_start/mm_done are one-cycle pulses; mm_a/mm_b/mm_n are held from
// mm_start until mm_done. dbg_state exposes the FSM state for checkers.
module rsa_modexp_ctrl
  import rsa_pkg::*;
#(
  parameter int WIDTH = RSA_WIDTH,
  parameter int EXP_W = RSA_EXP_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     data_rx,
  input  logic [EXP_W-1:0]     exp_e,
  input  logic [WIDTH-1:0]     mod_n,
  output logic                 mm_start,
  output logic [WIDTH-1:0]     mm_a,
  output logic [WIDTH-1:0]     mm_b,
  output logic [WIDTH-1:0]     mm_n,
  input  logic                 mm_done,
  input  logic [WIDTH-1:0]     mm_p,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     output_e,
  output logic                 err,
  output modexp_state_e        dbg_state
);

  localparam int IDX_W = (EXP_W > 1) ? $clog2(EXP_W) : 1;

  modexp_state_e    state_q, state_d;
  logic [WIDTH-1:0] acc_q,   acc_d;
  logic [WIDTH-1:0] base_q,  base_d;
  logic [WIDTH-1:0] mod_q,   mod_d;
  logic [EXP_W-1:0] exp_q,   exp_d;
  logic [IDX_W-1:0] idx_q,   idx_d;
  logic             err_q,   err_d;

`ifdef RSA_EXP_SKIP_EN
  logic [IDX_W-1:0] msb_k;

  // Index of the most significant set bit (0 when no bit is set).
  function automatic logic [IDX_W-1:0] msb_index(input logic [EXP_W-1:0] e);
    logic [IDX_W-1:0] k;
    k = '0;
    for (int b = 0; b < EXP_W; b++) begin
      if (e[b]) k = IDX_W'(b);
    end
    return k;
  endfunction

  // MSB position of the latched exponent, used only in CHECK.
  always_comb begin
    msb_k = msb_index(exp_q);
  end
`endif

  // State and datapath registers; reset abandons any in-flight product.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      acc_q   <= '0;
      base_q  <= '0;
      mod_q   <= '0;
      exp_q   <= '0;
      idx_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      base_q  <= base_d;
      mod_q   <= mod_d;
      exp_q   <= exp_d;
      idx_q   <= idx_d;
      err_q   <= err_d;
    end
  end

  // Next-state logic: operand capture, validation and bit scheduling.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    base_d  = base_q;
    mod_d   = mod_q;
    exp_d   = exp_q;
    idx_d   = idx_q;
    err_d   = err_q;

    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          base_d  = data_rx;
          exp_d   = exp_e;
          mod_d   = mod_n;
          err_d   = 1'b0;
          state_d = ST_CHECK;
        end
      end

      ST_CHECK: begin
        if ((mod_q < WIDTH'(MODEXP_MIN_MOD)) || (base_q >= mod_q)) begin
          acc_d   = '0;
          err_d   = 1'b1;
          state_d = ST_DONE;
        end else if (exp_q == '0) begin
          acc_d   = WIDTH'(1);
          state_d = ST_DONE;
        end else begin
`ifdef RSA_EXP_SKIP_EN
          // The leading 1 bit is absorbed by starting from acc=base.
          acc_d = base_q;
          if (msb_k == '0) begin
            state_d = ST_DONE;
          end else begin
            idx_d   = msb_k - IDX_W'(1);
            state_d = ST_SQR_ISSUE;
          end
`else
          acc_d   = WIDTH'(1);
          idx_d   = IDX_W'(EXP_W - 1);
          state_d = ST_SQR_ISSUE;
`endif
        end
      end

      ST_SQR_ISSUE: state_d = ST_SQR_WAIT;

      ST_SQR_WAIT: begin
        if (mm_done) begin
          acc_d = mm_p;
          if (exp_q[idx_q]) begin
            state_d = ST_MUL_ISSUE;
          end else if (idx_q == '0) begin
            state_d = ST_DONE;
          end else begin
            idx_d   = idx_q - IDX_W'(1);
            state_d = ST_SQR_ISSUE;
          end
        end
      end

      ST_MUL_ISSUE: state_d = ST_MUL_WAIT;

      ST_MUL_WAIT: begin
        if (mm_done) begin
          acc_d = mm_p;
          if (idx_q == '0) begin
            state_d = ST_DONE;
          end else begin
            idx_d   = idx_q - IDX_W'(1);
            state_d = ST_SQR_ISSUE;
          end
        end
      end

      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // Output decode: multiplier operands follow acc/base, result gated to DONE.
  always_comb begin
    in_ready  = rst && (state_q == ST_IDLE);
    mm_start  = (state_q == ST_SQR_ISSUE) || (state_q == ST_MUL_ISSUE);
    mm_a      = acc_q;
    mm_b      = ((state_q == ST_MUL_ISSUE) || (state_q == ST_MUL_WAIT)) ? base_q : acc_q;
    mm_n      = mod_q;
    out_valid = (state_q == ST_DONE);
    output_e  = (state_q == ST_DONE) ? acc_q : '0;
    err       = (state_q == ST_DONE) && err_q;
    dbg_state = state_q;
  end

endmodule

// File: tb/tb_rsa_modexp_ctrl.sv
// Bench for rsa_modexp_ctrl with a behavioural 3-cycle modular multiplier.
// Build with +define+RSA_EXP_SKIP_EN to check the MSB-skip build.
module tb_rsa_modexp_ctrl;
  import rsa_pkg::*;

  localparam int W = 32;
  localparam int E = 32;
`ifdef RSA_EXP_SKIP_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  data_rx = '0;
  logic [E-1:0]  exp_e = '0;
  logic [W-1:0]  mod_n = '0;
  logic          mm_start;
  logic [W-1:0]  mm_a, mm_b, mm_n;
  logic          mm_done = 1'b0;
  logic [W-1:0]  mm_p = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [W-1:0]  output_e;
  logic          err;
  modexp_state_e dbg_state;

  rsa_modexp_ctrl #(.WIDTH(W), .EXP_W(E)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .data_rx(data_rx), .exp_e(exp_e), .mod_n(mod_n),
    .mm_start(mm_start), .mm_a(mm_a), .mm_b(mm_b), .mm_n(mm_n),
    .mm_done(mm_done), .mm_p(mm_p),
    .out_valid(out_valid), .out_ready(out_ready),
    .output_e(output_e), .err(err), .dbg_state(dbg_state)
  );

  // ---------------- behavioural multiplier (L=3, not reset) ----------------
  // The product is formed from the operands present at completion, so any
  // operand change during the wait corrupts the result.
  logic [2:0] mm_cnt = 3'd0;
  int         start_cnt = 0;
  always @(posedge clk) begin
    mm_done <= 1'b0;
    if (mm_start) begin
      mm_cnt    <= 3'd3;
      start_cnt <= start_cnt + 1;
    end else if (mm_cnt != 3'd0) begin
      mm_cnt <= mm_cnt - 3'd1;
      if (mm_cnt == 3'd1) begin
        mm_done <= 1'b1;
        if (mm_n == '0) mm_p <= '0;
        else            mm_p <= W'((64'(mm_a) * 64'(mm_b)) % 64'(mm_n));
      end
    end
  end

  // ---------------- scoreboard counters ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0d, required %0d", name, act, req);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [W-1:0] base;
    logic [E-1:0] expo;
    logic [W-1:0] modn;
    logic [W-1:0] res;
    logic         err;
    int           starts_full;
    int           starts_skip;
  } vec_t;

  vec_t vecs[10];

  // ---------------- driver tasks ----------------
  // Present operands at a falling edge and complete the input handshake.
  task automatic send(input logic [W-1:0] b, input logic [E-1:0] e,
                      input logic [W-1:0] m, output int s0);
    int waited;
    @(negedge clk);
    in_valid = 1'b1;
    data_rx  = b;
    exp_e    = e;
    mod_n    = m;
    waited   = 0;
    while (!in_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    check("in_ready_before_accept", in_ready, 1);
    s0 = start_cnt;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Rising edges from the accept edge (inclusive) until out_valid is seen.
  task automatic wait_out(output int lat, output bit seen);
    lat  = 1;
    seen = 1'b0;
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      if (out_valid) begin
        seen = 1'b1;
        break;
      end
      lat++;
    end
  endtask

  task automatic run_vec(input vec_t v, input int id);
    int s0, lat, exp_starts;
    bit seen;
    string tag;
    tag = $sformatf("vec%0d", id);
    send(v.base, v.expo, v.modn, s0);
    wait_out(lat, seen);
    check({tag, "_out_valid_seen"}, seen, 1);
    check({tag, "_output_e"}, output_e, v.res);
    check({tag, "_err"}, err, v.err);
    exp_starts = SKIP ? v.starts_skip : v.starts_full;
    check({tag, "_mm_start_count"}, start_cnt - s0, exp_starts);
    if (v.err || v.expo == '0) check({tag, "_latency"}, lat, 2);
    @(posedge clk);
    #1;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int s0, lat, waited;
    bit seen;

    vecs[0] = '{base: 65,   expo: 17,           modn: 3233, res: 2790, err: 0, starts_full: 34, starts_skip: 5};
    vecs[1] = '{base: 2,    expo: 17,           modn: 3233, res: 1752, err: 0, starts_full: 34, starts_skip: 5};
    vecs[2] = '{base: 5,    expo: 0,            modn: 7,    res: 1,    err: 0, starts_full: 0,  starts_skip: 0};
    vecs[3] = '{base: 3233, expo: 5,            modn: 3233, res: 0,    err: 1, starts_full: 0,  starts_skip: 0};
    vecs[4] = '{base: 0,    expo: 3,            modn: 1,    res: 0,    err: 1, starts_full: 0,  starts_skip: 0};
    vecs[5] = '{base: 4,    expo: 1,            modn: 7,    res: 4,    err: 0, starts_full: 33, starts_skip: 0};
    vecs[6] = '{base: 3,    expo: 32'h80000000, modn: 7,    res: 2,    err: 0, starts_full: 33, starts_skip: 31};
    vecs[7] = '{base: 7,    expo: 32'hFFFFFFFF, modn: 11,   res: 10,   err: 0, starts_full: 64, starts_skip: 62};
    vecs[8] = '{base: 3232, expo: 2,            modn: 3233, res: 1,    err: 0, starts_full: 33, starts_skip: 1};
    vecs[9] = '{base: 0,    expo: 5,            modn: 7,    res: 0,    err: 0, starts_full: 34, starts_skip: 3};

    // Reset values while rst is low.
    #2;
    check("rst_in_ready", in_ready, 0);
    check("rst_mm_start", mm_start, 0);
    check("rst_mm_operands", {mm_a, mm_b, mm_n}, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_output_e", output_e, 0);
    check("rst_err", err, 0);
    check("rst_state", dbg_state, ST_IDLE);
    #8;
    rst = 1'b1;
    #2;
    check("post_rst_in_ready", in_ready, 1);

    // Table-driven vectors.
    for (int i = 0; i < 10; i++) run_vec(vecs[i], i);

    // Held result: out_ready low for 5 cycles in DONE.
    out_ready = 1'b0;
    send(65, 17, 3233, s0);
    wait_out(lat, seen);
    check("hold_seen", seen, 1);
    for (int c = 0; c < 5; c++) begin
      check("hold_out_valid", out_valid, 1);
      check("hold_output_e", output_e, 2790);
      check("hold_in_ready", in_ready, 0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("release_in_ready", in_ready, 1);
    send(2, 17, 3233, s0);
    wait_out(lat, seen);
    check("b2b_seen", seen, 1);
    check("b2b_output_e", output_e, 1752);
    @(posedge clk);
    #1;

    // Reset during MUL_WAIT, then a stray mm_done from the abandoned product.
    send(65, 17, 3233, s0);
    waited = 0;
    while (dbg_state != ST_MUL_WAIT && waited < 500) begin
      @(negedge clk);
      waited++;
    end
    check("reached_mul_wait", dbg_state, ST_MUL_WAIT);
    rst = 1'b0;
    #1;
    check("midrst_state", dbg_state, ST_IDLE);
    check("midrst_in_ready", in_ready, 0);
    check("midrst_mm", {mm_start, mm_a, mm_b, mm_n}, 0);
    check("midrst_out", {out_valid, err, output_e}, 0);
    @(negedge clk);
    rst = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      check("stray_done_ignored", {dbg_state, out_valid, mm_start, in_ready},
            {ST_IDLE, 1'b0, 1'b0, 1'b1});
    end
    run_vec(vecs[0], 100);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/rsa_modexp_ctrl.md
# rsa_modexp_ctrl

Sequencing controller for RSA modular exponentiation. It accepts a message, exponent and modulus over a valid/ready handshake. It computes output_e = data_rx^exp_e mod mod_n by left-to-right square-and-multiply, issuing each modular product to one shared modular multiplier over a start/done handshake. It sits between the encryption front end and the multiplier datapath, and owns all operand and exponent-bit scheduling.

## Interface
- WIDTH, 32, width of message, modulus and result
- EXP_W, 32, width of exponent
- clk  in  1  system clock, rising edge
- rst  in  1  reset, asynchronous assert, active-low (0 = reset)
- in_valid  in  1  operands presented
- in_ready  out  1  controller can accept operands (IDLE only)
- data_rx  in  WIDTH  message/base
- exp_e  in  EXP_W  exponent
- mod_n  in  WIDTH  modulus
- mm_start  out  1  one-cycle pulse: start product mm_a*mm_b mod mm_n
- mm_a, mm_b, mm_n  out  WIDTH  multiplier operands, stable from mm_start until mm_done
- mm_done  in  1  one-cycle pulse: mm_p valid
- mm_p  in  WIDTH  multiplier product
- out_valid  out  1  result available
- out_ready  in  1  consumer accepts result
- output_e  out  WIDTH  result
- err  out  1  qualifies out_valid: operands rejected

## Operation
- States: IDLE, CHECK, SQR_ISSUE, SQR_WAIT, MUL_ISSUE, MUL_WAIT, DONE.
- IDLE: in_ready=1. On in_valid&&in_ready, latch data_rx/exp_e/mod_n and go to CHECK.
- CHECK:
  - If mod_n<2 or data_rx>=mod_n: result=0, err=1, go to DONE.
  - Else if exp_e==0: result=1, err=0, go to DONE.
  - Else initialise acc=1 and bit index i=EXP_W-1, then go to SQR_ISSUE.
- SQR_ISSUE: mm_a=mm_b=acc, pulse mm_start, go to SQR_WAIT.
- SQR_WAIT: on mm_done, acc=mm_p.
  - If exp_e[i]=1, go to MUL_ISSUE.
  - Else if i==0, go to DONE.
  - Else decrement i and go to SQR_ISSUE.
- MUL_ISSUE: mm_a=acc, mm_b=base, pulse mm_start, go to MUL_WAIT.
- MUL_WAIT: on mm_done, acc=mm_p. If i==0 go to DONE, else decrement i and go to SQR_ISSUE.
- DONE: out_valid=1, output_e=acc. When out_ready=1, return to IDLE.
- Width rules:
  - Bit index counter is clog2(EXP_W) wide and must not wrap below 0; the i==0 check precedes the decrement.
  - mm_n always equals the latched mod_n.
  - mm_p is trusted to be < mod_n; no reduction in this block.
- mm_done outside SQR_WAIT/MUL_WAIT is ignored.
- in_valid while busy is ignored; operands are not re-latched.
- Product count without the config feature: EXP_W + popcount(exp_e).

## Timing
- Reset values: in_ready=0 while rst=0, then 1 in IDLE. mm_start=0, mm_a=mm_b=mm_n=0, out_valid=0, output_e=0, err=0, state=IDLE.
- Reset mid-operation clears immediately. An in-flight multiplier result is discarded; mm_done after reset is ignored.
- Capture to CHECK: 1 cycle. CHECK: 1 cycle.
- Each product takes 1 issue cycle plus the multiplier latency L to mm_done, plus 1 cycle to the next state.
- Error and exp_e==0 paths: out_valid asserts 2 cycles after the accept edge.
- out_valid, output_e and err are held stable until the out_ready handshake. If out_ready is already high in DONE, out_valid lasts 1 cycle.
- Back-to-back: in_ready rises the cycle after the output handshake.

## Configuration
- RSA_EXP_SKIP_EN defined:
  - CHECK finds the MSB set bit k of exp_e, sets acc=base and i=k.
  - If k==0, go to DONE with acc=base.
  - Otherwise decrement i and go to SQR_ISSUE.
  - Product count is k + popcount(exp_e) - 1.
- Undefined: full scan from EXP_W-1 starting at acc=1, as in Operation.
- Results are identical in both builds; only cycle count and mm_start count differ.

## Structure
- Shared package rsa_pkg holds:
  - state enum
  - default WIDTH/EXP_W constants
  - the MODEXP_MIN_MOD=2 constant
- Natural sub-module: rsa_modmul, the shared sequential modular multiplier. It is instantiated at the level above, not inside this block.
- Priority-encoder for MSB detection is a local function, compiled only under RSA_EXP_SKIP_EN.

## Test plan
Bench: behavioural multiplier with L=3, clk period 10 ns, rst low for 10 ns.
- data_rx=65, exp_e=17, mod_n=3233 -> output_e=2790, err=0. mm_start count: 34 without the macro, 5 with it.
- data_rx=2, exp_e=17, mod_n=3233 -> output_e=1752.
- exp_e=0, data_rx=5, mod_n=7 -> output_e=1, err=0, no mm_start, out_valid 2 cycles after accept.
- data_rx=3233, mod_n=3233 -> err=1, output_e=0. Repeat with mod_n=1 -> err=1.
- Hold out_ready=0 for 5 cycles in DONE -> output_e/out_valid stable, in_ready=0. Release -> in_ready=1 next cycle, second operand set accepted.
- Assert rst=0 during MUL_WAIT, then send stray mm_done -> all outputs at reset values, state IDLE. Next request computes correctly.
